// File: rtl/parity_unit.sv
// Parity generator/checker for the UART datapath.
// TX half: latches a parallel word and presents the selected parity bit.
// RX half: accumulates parity serially, checks the received parity bit and
// reports a registered error together with a one-cycle completion pulse.
module parity_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic [1:0]       PAR_TYP,
    input  logic             RX_START,
    input  logic             SAMPLE_STRB,
    input  logic             SAMPLED_BIT,
    output logic             par_bit,
    output logic             rx_busy,
    output logic             chk_done,
    output logic             par_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar
    } rx_state_e;

    // Mode mapping shared by TX generation and RX checking; x is the XOR of the data.
    function automatic logic calc_par(input logic en, input logic [1:0] typ, input logic x);
        logic p;
        p = 1'b0;
        if (en) begin
            unique case (typ)
                2'b00:   p = x;
                2'b01:   p = ~x;
                2'b10:   p = 1'b1;
                default: p = 1'b0;
            endcase
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic [1:0]       tx_typ_q, tx_typ_d;

    // TX load: capture word and mode only on Data_Valid.
    always_comb begin
        tx_data_d = tx_data_q;
        tx_en_d   = tx_en_q;
        tx_typ_d  = tx_typ_q;
        if (Data_Valid) begin
            tx_data_d = P_DATA;
            tx_en_d   = PAR_EN;
            tx_typ_d  = PAR_TYP;
        end
    end

    // TX registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            tx_typ_q  <= 2'b00;
        end else begin
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_typ_q  <= tx_typ_d;
        end
    end

    // TX parity output, combinational from the latched registers.
    always_comb begin
        par_bit = calc_par(tx_en_q, tx_typ_q, ^tx_data_q);
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            rx_en_q, rx_en_d;
    logic [1:0]      rx_typ_q, rx_typ_d;
    logic            par_err_q, par_err_d;
    logic            chk_done_q, chk_done_d;

    // RX next state; RX_START takes priority over any strobe in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rx_en_d    = rx_en_q;
        rx_typ_d   = rx_typ_q;
        par_err_d  = par_err_q;
        chk_done_d = 1'b0;
        if (RX_START) begin
            state_d   = StData;
            cnt_d     = '0;
            acc_d     = 1'b0;
            par_err_d = 1'b0;
            rx_en_d   = PAR_EN;
            rx_typ_d  = PAR_TYP;
        end else if (SAMPLE_STRB) begin
            unique case (state_q)
                StData: begin
                    acc_d = acc_q ^ SAMPLED_BIT;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        if (rx_en_q) begin
                            state_d = StPar;
                        end else begin
                            state_d    = StIdle;
                            chk_done_d = 1'b1;
                            par_err_d  = 1'b0;
                        end
                    end
                end
                StPar: begin
                    par_err_d  = SAMPLED_BIT != calc_par(rx_en_q, rx_typ_q, acc_q);
                    chk_done_d = 1'b1;
                    state_d    = StIdle;
                end
                default: ;
            endcase
        end
    end

    // RX registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            rx_en_q    <= 1'b0;
            rx_typ_q   <= 2'b00;
            par_err_q  <= 1'b0;
            chk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rx_en_q    <= rx_en_d;
            rx_typ_q   <= rx_typ_d;
            par_err_q  <= par_err_d;
            chk_done_q <= chk_done_d;
        end
    end

    // RX outputs.
    always_comb begin
        rx_busy  = state_q != StIdle;
        chk_done = chk_done_q;
        par_err  = par_err_q;
    end

endmodule

// File: tb/tb_parity_unit.sv
// Scoreboard bench for parity_unit: stimulus pushes expected results,
// monitors pop and compare when the DUT presents them.
module tb_parity_unit;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid, PAR_EN, RX_START, SAMPLE_STRB, SAMPLED_BIT;
    logic [1:0] PAR_TYP;
    logic       par_bit, rx_busy, chk_done, par_err;

    logic [4:0] p5;
    logic       dv5, en5, st5, sb5, bit5;
    logic [1:0] typ5;
    logic       par5, busy5, done5, err5;

    parity_unit #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .RX_START(RX_START),
        .SAMPLE_STRB(SAMPLE_STRB), .SAMPLED_BIT(SAMPLED_BIT),
        .par_bit(par_bit), .rx_busy(rx_busy), .chk_done(chk_done), .par_err(par_err)
    );

    parity_unit #(.WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(p5), .Data_Valid(dv5),
        .PAR_EN(en5), .PAR_TYP(typ5), .RX_START(st5),
        .SAMPLE_STRB(sb5), .SAMPLED_BIT(bit5),
        .par_bit(par5), .rx_busy(busy5), .chk_done(done5), .par_err(err5)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   done5_cnt = 0;
    logic exp_tx_q[$];
    logic exp_rx_q[$];
    logic exp_rx5_q[$];
    logic dv_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // TX monitor: par_bit is compared in the cycle after each Data_Valid.
    always @(posedge CLK) dv_seen <= Data_Valid;
    always @(negedge CLK) begin
        if (dv_seen) begin
            if (exp_tx_q.size() == 0) check("tx_unexpected_load", 1, 0);
            else check("tx_par_bit", int'(par_bit), int'(exp_tx_q.pop_front()));
        end
    end

    // RX monitors: compare par_err on every chk_done pulse.
    always @(negedge CLK) begin
        if (chk_done) begin
            done_cnt++;
            if (exp_rx_q.size() == 0) check("rx_unexpected_done", 1, 0);
            else begin
                check("rx_par_err", int'(par_err), int'(exp_rx_q.pop_front()));
                check("rx_busy_at_done", int'(rx_busy), 0);
            end
        end
    end
    always @(negedge CLK) begin
        if (done5) begin
            done5_cnt++;
            if (exp_rx5_q.size() == 0) check("rx5_unexpected_done", 1, 0);
            else check("rx5_par_err", int'(err5), int'(exp_rx5_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tx_load(input logic [7:0] d, input logic en, input logic [1:0] typ,
                           input logic exp);
        P_DATA = d; PAR_EN = en; PAR_TYP = typ; Data_Valid = 1'b1;
        exp_tx_q.push_back(exp);
        tick();
        Data_Valid = 1'b0;
    endtask

    task automatic rx_start(input logic en, input logic [1:0] typ);
        RX_START = 1'b1; PAR_EN = en; PAR_TYP = typ;
        tick();
        RX_START = 1'b0;
    endtask

    task automatic strobe(input logic b);
        SAMPLE_STRB = 1'b1; SAMPLED_BIT = b;
        tick();
        SAMPLE_STRB = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic par, input logic exp_err);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        exp_rx_q.push_back(exp_err);
        strobe(par);
    endtask

    int c0;

    initial begin
        RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 2'b00;
        RX_START = 1'b0; SAMPLE_STRB = 1'b0; SAMPLED_BIT = 1'b0;
        p5 = '0; dv5 = 1'b0; en5 = 1'b0; typ5 = 2'b00; st5 = 1'b0; sb5 = 1'b0; bit5 = 1'b0;
        tick(); tick();
        check("rst_par_bit", int'(par_bit), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        check("rst_chk_done", int'(chk_done), 0);
        check("rst_par_err", int'(par_err), 0);
        check("rst5_par_bit", int'(par5), 0);
        check("rst5_rx_busy", int'(busy5), 0);
        RST = 1'b1;
        tick();

        // TX modes: 0xA5 has four ones.
        tx_load(8'hA5, 1'b1, 2'b00, 1'b0);
        tx_load(8'hA5, 1'b1, 2'b01, 1'b1);
        P_DATA = 8'h01; PAR_TYP = 2'b00;
        tick(); tick();
        check("tx_hold_without_load", int'(par_bit), 1);
        tx_load(8'h00, 1'b1, 2'b10, 1'b1);
        tx_load(8'h00, 1'b1, 2'b11, 1'b0);
        tx_load(8'h00, 1'b0, 2'b10, 1'b0);
        tx_load(8'hA5, 1'b0, 2'b01, 1'b0);

        // RX even: 0x37 has five ones, so even parity bit is 1.
        rx_start(1'b1, 2'b00);
        check("rx_busy_after_start", int'(rx_busy), 1);
        rx_frame(8'h37, 1'b1, 1'b0);
        check("rx_done_cycle", int'(chk_done), 1);
        tick();
        check("rx_done_one_cycle", int'(chk_done), 0);
        rx_start(1'b1, 2'b00);
        rx_frame(8'h37, 1'b0, 1'b1);
        tick(); tick(); tick();
        check("rx_err_held", int'(par_err), 1);

        // Abort: restart mid-frame, second start collides with a strobe.
        rx_start(1'b1, 2'b01);
        check("rx_err_cleared_on_start", int'(par_err), 0);
        check("rx_busy_restart", int'(rx_busy), 1);
        c0 = done_cnt;
        strobe(1'b1); strobe(1'b1); strobe(1'b1);
        RX_START = 1'b1; SAMPLE_STRB = 1'b1; SAMPLED_BIT = 1'b1; PAR_EN = 1'b1; PAR_TYP = 2'b01;
        tick();
        RX_START = 1'b0; SAMPLE_STRB = 1'b0;
        rx_frame(8'h01, 1'b0, 1'b0);
        tick(); tick();
        check("rx_abort_single_done", done_cnt - c0, 1);

        // Reset mid-frame.
        tx_load(8'h00, 1'b1, 2'b10, 1'b1);
        rx_start(1'b1, 2'b00);
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
        RST = 1'b0;
        #1;
        check("midrst_par_bit", int'(par_bit), 0);
        check("midrst_rx_busy", int'(rx_busy), 0);
        check("midrst_chk_done", int'(chk_done), 0);
        check("midrst_par_err", int'(par_err), 0);
        tick();
        RST = 1'b1;
        c0 = done_cnt;
        for (int i = 0; i < 10; i++) strobe(i[0]);
        tick(); tick();
        check("idle_strobes_no_done", done_cnt - c0, 0);
        check("idle_strobes_not_busy", int'(rx_busy), 0);

        // WIDTH=5, parity disabled.
        st5 = 1'b1; en5 = 1'b0; typ5 = 2'b00;
        tick();
        st5 = 1'b0;
        check("rx5_busy_after_start", int'(busy5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_rx5_q.push_back(1'b0);
            sb5 = 1'b1; bit5 = ~i[0];
            tick();
            sb5 = 1'b0;
        end
        check("rx5_done_after_fifth", int'(done5), 1);
        check("rx5_busy_done", int'(busy5), 0);
        check("rx5_err", int'(err5), 0);
        sb5 = 1'b1; bit5 = 1'b1;
        tick();
        sb5 = 1'b0;
        check("rx5_sixth_not_busy", int'(busy5), 0);
        tick(); tick();
        check("rx5_done_count", done5_cnt, 1);

        // Drain: every pushed expectation must have been consumed.
        for (int i = 0; i < 20; i++) begin
            if (exp_tx_q.size() == 0 && exp_rx_q.size() == 0 && exp_rx5_q.size() == 0) break;
            tick();
        end
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("rx_queue_drained", exp_rx_q.size(), 0);
        check("rx5_queue_drained", exp_rx5_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_unit.md
# parity_unit

Parametrised parity generator/checker for the UART datapath, superseding the TX-only parity calculator. The TX half latches a parallel word on `Data_Valid` and presents the parity bit selected by one of four modes. The RX half accumulates parity serially from sampled frame bits, compares it against the received parity bit, and reports a registered error with a completion pulse. Both halves share clock and reset and are otherwise independent.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 5..16.
- `CLK`  in  1  system clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  WIDTH  TX parallel word.
- `Data_Valid`  in  1  TX load strobe; latches `P_DATA`, `PAR_EN`, `PAR_TYP`.
- `PAR_EN`  in  1  parity enable; sampled on `Data_Valid` (TX) and on `RX_START` (RX).
- `PAR_TYP`  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0); sampled with `PAR_EN`.
- `RX_START`  in  1  one-cycle pulse; begins a new RX frame (after the start bit is validated).
- `SAMPLE_STRB`  in  1  one-cycle pulse; `SAMPLED_BIT` is valid.
- `SAMPLED_BIT`  in  1  received bit, LSB first, then the parity bit.
- `par_bit`  out  1  TX parity bit.
- `rx_busy`  out  1  high while an RX frame is in progress.
- `chk_done`  out  1  one-cycle pulse; the RX check is complete.
- `par_err`  out  1  RX parity mismatch; held until the next `RX_START` or reset.

## Operation
- **TX path**
  - Registers: `tx_data`, `tx_en`, `tx_typ`. All load on `Data_Valid`; otherwise they hold.
  - `par_bit` is combinational from the registers:
    - `tx_en`=0 → 0.
    - even → `^tx_data`.
    - odd → `~^tx_data`.
    - mark → 1.
    - space → 0.
  - `P_DATA`/`PAR_*` changes without `Data_Valid` have no effect.
- **RX path**: FSM with states IDLE, DATA, PAR.
  - IDLE: on `RX_START`, latch `rx_en`/`rx_typ`, clear accumulator, bit counter, and `par_err`; go to DATA.
  - DATA: each `SAMPLE_STRB` XORs `SAMPLED_BIT` into the accumulator and increments the counter (width clog2(WIDTH+1)). On the strobe that makes count == WIDTH:
    - if `rx_en`=1 → go to PAR;
    - if `rx_en`=0 → go to IDLE, pulse `chk_done`, `par_err`=0.
  - PAR: on `SAMPLE_STRB`, compare `SAMPLED_BIT` with the expected bit, computed by the same mode mapping as TX over the accumulated data. Set `par_err` to the mismatch, pulse `chk_done`, go to IDLE.
  - `rx_busy` = (state != IDLE).
- **Boundary rules**
  - `RX_START` in any state restarts the frame; partial data is discarded; no `chk_done` for the aborted frame.
  - `RX_START` and `SAMPLE_STRB` in the same cycle: `RX_START` wins and the strobe is ignored.
  - `SAMPLE_STRB` in IDLE is ignored.
  - TX and RX are fully concurrent; `Data_Valid` never disturbs RX state.
- **Reset** (async assert, sync release):
  - `tx_data`=0, `tx_en`=0, `tx_typ`=00, so `par_bit`=0.
  - state=IDLE, counter=0, accumulator=0.
  - `rx_busy`=0, `chk_done`=0, `par_err`=0.

## Timing
- **TX**: `Data_Valid` high at edge N → new `par_bit` valid after edge N (usable in cycle N+1); latency 1 cycle. Stable until the next `Data_Valid`.
- **RX**:
  - `RX_START` at edge N → `rx_busy`=1 from cycle N+1; `par_err` clears at the same edge.
  - Completing strobe at edge M → `chk_done`=1 and `par_err` valid during cycle M+1; `rx_busy`=0 in cycle M+1.
  - `chk_done` is exactly one cycle wide.
  - `RX_START` may be asserted in cycle M+1 (back-to-back frames).
- **Strobe spacing**: strobes may arrive on consecutive cycles (minimum spacing 1); no gap requirement.

## Test plan
- **TX modes**: `P_DATA`=0xA5, `PAR_EN`=1, `Data_Valid` pulse with `PAR_TYP`=00 → `par_bit`=0; reload with 01 → 1. Change `P_DATA` to 0x01 without `Data_Valid` → `par_bit` unchanged.
- **TX mark/space/disabled**: 0x00 with 10 → 1; with 11 → 0; `PAR_EN`=0, any type → 0.
- **RX even**: `RX_START`, strobe 0x37 LSB first, then parity 1 → `chk_done` pulse, `par_err`=0. Repeat with parity 0 → `par_err`=1, held until the next `RX_START`.
- **RX abort**: `RX_START`, 3 strobes, `RX_START` again, then 0x01 with odd parity and parity bit 0 → exactly one `chk_done`, `par_err`=0.
- **Reset mid-frame**: `RST` low after 4 data strobes → all outputs 0, state IDLE. Further strobes without `RX_START` → no `chk_done`.
- **WIDTH=5, disabled**: `RX_START` with `PAR_EN`=0, 5 strobes → `chk_done` in the cycle after the 5th strobe, `par_err`=0. A 6th strobe is ignored and `rx_busy` stays 0.
